// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: instruction kinds, retire FSM states
// and the per-entry record kept in the circular buffer.
package reorder_buffer_pkg;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_STORE  = 2'd1,
    KIND_BRANCH = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    RT_IDLE    = 2'd0,
    RT_ST_REQ  = 2'd1,
    RT_ST_WAIT = 2'd2
  } rt_state_e;

  // Value the commit tag shows when nothing has retired yet
  localparam logic [5:0] TAG_NULL = 6'd0;

  typedef struct packed {
    logic        busy;
    logic        ready;
    kind_e       kind;
    logic [5:0]  rd;
    logic [31:0] pc;
    logic [31:0] predPc;
    logic [31:0] value;
    logic [31:0] addr;
    logic [31:0] realPc;
  } rob_entry_t;

  function automatic logic isMispredict(input rob_entry_t e);
    return e.realPc != e.predPc;
  endfunction

endpackage

// File: rtl/rob_lookup.sv
// Operand lookup for one source: reads the entry by tag, overridden by a
// same-cycle writeback on that tag (lowest channel index wins).
module rob_lookup #(
  parameter  int DEPTH     = 32,
  parameter  int CDB_PORTS = 3,
  localparam int TAG_W     = $clog2(DEPTH)
) (
  input  logic [TAG_W-1:0]           qryTag_i,
  input  logic [DEPTH-1:0]           entReady_i,
  input  logic [DEPTH-1:0][31:0]     entValue_i,
  input  logic [CDB_PORTS-1:0]       wbValid_i,
  input  logic [CDB_PORTS*TAG_W-1:0] wbTag_i,
  input  logic [CDB_PORTS*32-1:0]    wbValue_i,
  output logic                       ready_o,
  output logic [31:0]                value_o
);

  // Scan from the highest channel down so the lowest matching one is last to write
  always_comb begin
    ready_o = entReady_i[qryTag_i];
    value_o = entValue_i[qryTag_i];
    for (int c = CDB_PORTS - 1; c >= 0; c--) begin
      if (wbValid_i[c] && (wbTag_i[c*TAG_W +: TAG_W] == qryTag_i)) begin
        ready_o = 1'b1;
        value_o = wbValue_i[c*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-flight instruction store with multi-port
// writeback, operand bypass lookup and in-order retirement incl. stores/flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter  int DEPTH     = 32,
  parameter  int CDB_PORTS = 3,
  localparam int TAG_W     = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       alloc_valid,
  input  logic [1:0]                 alloc_kind,
  input  logic [5:0]                 alloc_rd,
  input  logic [31:0]                alloc_pc,
  input  logic [31:0]                alloc_pred_pc,
  output logic [TAG_W-1:0]           alloc_tag,
  output logic                       rob_full,
  output logic                       rob_empty,
  input  logic [CDB_PORTS-1:0]       wb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0] wb_tag,
  input  logic [CDB_PORTS*32-1:0]    wb_value,
  input  logic [CDB_PORTS*32-1:0]    wb_addr,
  input  logic [CDB_PORTS*32-1:0]    wb_real_pc,
  input  logic [2*TAG_W-1:0]         qry_tag,
  output logic [1:0]                 qry_ready,
  output logic [63:0]                qry_value,
  output logic                       commit_valid,
  output logic [TAG_W-1:0]           commit_tag,
  output logic [5:0]                 commit_rd,
  output logic [31:0]                commit_value,
  output logic                       st_req,
  output logic [31:0]                st_addr,
  output logic [31:0]                st_data,
  input  logic                       st_grant,
  input  logic                       st_done,
  output logic                       bp_update_valid,
  output logic [31:0]                bp_pc,
  output logic                       bp_mispredict,
  output logic                       flush,
  output logic [31:0]                redirect_pc
);

  localparam int CNT_W = TAG_W + 1;

  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  rt_state_e        state_q, state_d;

  logic             commitValid_q, commitValid_d;
  logic [TAG_W-1:0] commitTag_q, commitTag_d;
  logic [5:0]       commitRd_q, commitRd_d;
  logic [31:0]      commitValue_q, commitValue_d;
  logic             stReq_q, stReq_d;
  logic [31:0]      stAddr_q, stAddr_d, stData_q, stData_d;
  logic             bpUpdateValid_q, bpUpdateValid_d;
  logic [31:0]      bpPc_q, bpPc_d;
  logic             bpMispredict_q, bpMispredict_d;
  logic             flushPulse_q, flushPulse_d;
  logic [31:0]      redirectPc_q, redirectPc_d;

  logic             retireFire, allocFire, doFlush;
  logic [TAG_W-1:0] wbTag;
  rob_entry_t       headEnt;
  logic [DEPTH-1:0]       entReady;
  logic [DEPTH-1:0][31:0] entValue;

  assign rob_full  = (count_q == CNT_W'(DEPTH));
  assign rob_empty = (count_q == '0);
  assign alloc_tag = tail_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entReady[i] = ent_q[i].busy && ent_q[i].ready;
      entValue[i] = ent_q[i].value;
    end
  end

  for (genvar q = 0; q < 2; q++) begin : gLookup
    rob_lookup #(.DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS)) u_lookup (
      .qryTag_i   (qry_tag[q*TAG_W +: TAG_W]),
      .entReady_i (entReady),
      .entValue_i (entValue),
      .wbValid_i  (wb_valid),
      .wbTag_i    (wb_tag),
      .wbValue_i  (wb_value),
      .ready_o    (qry_ready[q]),
      .value_o    (qry_value[q*32 +: 32])
    );
  end

  // Pulses default low every edge; with rdy low everything else simply holds
  always_comb begin
    ent_d           = ent_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    state_d         = state_q;
    commitValid_d   = 1'b0;
    commitTag_d     = commitTag_q;
    commitRd_d      = commitRd_q;
    commitValue_d   = commitValue_q;
    stReq_d         = stReq_q;
    stAddr_d        = stAddr_q;
    stData_d        = stData_q;
    bpUpdateValid_d = 1'b0;
    bpPc_d          = bpPc_q;
    bpMispredict_d  = bpMispredict_q;
    flushPulse_d    = 1'b0;
    redirectPc_d    = redirectPc_q;
    retireFire      = 1'b0;
    allocFire       = 1'b0;
    doFlush         = 1'b0;
    wbTag           = '0;
    headEnt         = ent_q[head_q];

    if (rdy) begin
      for (int c = CDB_PORTS - 1; c >= 0; c--) begin
        wbTag = wb_tag[c*TAG_W +: TAG_W];
        if (wb_valid[c] && ent_q[wbTag].busy) begin
          ent_d[wbTag].ready  = 1'b1;
          ent_d[wbTag].value  = wb_value[c*32 +: 32];
          ent_d[wbTag].addr   = wb_addr[c*32 +: 32];
          ent_d[wbTag].realPc = wb_real_pc[c*32 +: 32];
        end
      end

      case (state_q)
        RT_IDLE: begin
          if (headEnt.busy && headEnt.ready) begin
            case (headEnt.kind)
              KIND_STORE: begin
                stReq_d  = 1'b1;
                stAddr_d = headEnt.addr;
                stData_d = headEnt.value;
                state_d  = RT_ST_REQ;
              end
              KIND_BRANCH: begin
                bpUpdateValid_d = 1'b1;
                bpPc_d          = headEnt.pc;
                bpMispredict_d  = isMispredict(headEnt);
                if (isMispredict(headEnt)) begin
                  flushPulse_d = 1'b1;
                  redirectPc_d = headEnt.realPc;
                  doFlush      = 1'b1;
                end else begin
                  retireFire = 1'b1;
                end
              end
              default: begin
                commitValid_d = 1'b1;
                commitTag_d   = head_q;
                commitRd_d    = headEnt.rd;
                commitValue_d = headEnt.value;
                retireFire    = 1'b1;
              end
            endcase
          end
        end
        RT_ST_REQ: begin
          if (st_grant) begin
            stReq_d = 1'b0;
            if (st_done) begin
              retireFire = 1'b1;
              state_d    = RT_IDLE;
            end else begin
              state_d = RT_ST_WAIT;
            end
          end
        end
        RT_ST_WAIT: begin
          if (st_done) begin
            retireFire = 1'b1;
            state_d    = RT_IDLE;
          end
        end
        default: state_d = RT_IDLE;
      endcase

      if (retireFire) begin
        ent_d[head_q].busy  = 1'b0;
        ent_d[head_q].ready = 1'b0;
        head_d              = head_q + TAG_W'(1);
      end

      // Fullness is judged on current state, so a same-cycle retire cannot make room
      allocFire = alloc_valid && !rob_full && !doFlush;
      if (allocFire) begin
        ent_d[tail_q].busy   = 1'b1;
        ent_d[tail_q].ready  = 1'b0;
        ent_d[tail_q].kind   = kind_e'(alloc_kind);
        ent_d[tail_q].rd     = alloc_rd;
        ent_d[tail_q].pc     = alloc_pc;
        ent_d[tail_q].predPc = alloc_pred_pc;
        ent_d[tail_q].value  = '0;
        ent_d[tail_q].addr   = '0;
        ent_d[tail_q].realPc = '0;
        tail_d               = tail_q + TAG_W'(1);
      end

      count_d = count_q + CNT_W'(allocFire) - CNT_W'(retireFire);

      if (doFlush) begin
        for (int i = 0; i < DEPTH; i++) begin
          ent_d[i].busy  = 1'b0;
          ent_d[i].ready = 1'b0;
        end
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      state_q         <= RT_IDLE;
      commitValid_q   <= 1'b0;
      commitTag_q     <= TAG_NULL[TAG_W-1:0];
      commitRd_q      <= '0;
      commitValue_q   <= '0;
      stReq_q         <= 1'b0;
      stAddr_q        <= '0;
      stData_q        <= '0;
      bpUpdateValid_q <= 1'b0;
      bpPc_q          <= '0;
      bpMispredict_q  <= 1'b0;
      flushPulse_q    <= 1'b0;
      redirectPc_q    <= '0;
    end else begin
      ent_q           <= ent_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      state_q         <= state_d;
      commitValid_q   <= commitValid_d;
      commitTag_q     <= commitTag_d;
      commitRd_q      <= commitRd_d;
      commitValue_q   <= commitValue_d;
      stReq_q         <= stReq_d;
      stAddr_q        <= stAddr_d;
      stData_q        <= stData_d;
      bpUpdateValid_q <= bpUpdateValid_d;
      bpPc_q          <= bpPc_d;
      bpMispredict_q  <= bpMispredict_d;
      flushPulse_q    <= flushPulse_d;
      redirectPc_q    <= redirectPc_d;
    end
  end

  assign commit_valid    = commitValid_q;
  assign commit_tag      = commitTag_q;
  assign commit_rd       = commitRd_q;
  assign commit_value    = commitValue_q;
  assign st_req          = stReq_q;
  assign st_addr         = stAddr_q;
  assign st_data         = stData_q;
  assign bp_update_valid = bpUpdateValid_q;
  assign bp_pc           = bpPc_q;
  assign bp_mispredict   = bpMispredict_q;
  assign flush           = flushPulse_q;
  assign redirect_pc     = redirectPc_q;

endmodule
